// File: rtl/pcie_gearbox_pkg.sv
// Shared definitions for the PCIe RC/CC gearboxes: beat geometry, descriptor
// field offsets, state encoding and keep helpers.
package pcie_gearbox_pkg;

    localparam int DW_BITS  = 32;
    localparam int DESC_DW  = 3;
    localparam int BEAT_DW  = 8;

    localparam int DESC_BYTE_COUNT_LSB = 16;
    localparam int DESC_BYTE_COUNT_MSB = 28;

    typedef enum logic [1:0] {
        GB_IDLE  = 2'd0,
        GB_BODY  = 2'd1,
        GB_FLUSH = 2'd2
    } gb_state_e;

    // Low-aligned DW keep mask for a DW count of 0..8.
    function automatic logic [7:0] dw_count_to_keep(input logic [3:0] count);
        logic [7:0] keep;
        for (int i = 0; i < BEAT_DW; i++) begin
            keep[i] = (4'(i) < count);
        end
        return keep;
    endfunction

    function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < BEAT_DW; i++) begin
            cnt = cnt + {3'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_out_reg256.sv
// Single-stage AXI-Stream output register; loads whenever the downstream slot
// is empty or being drained, and holds everything stable while stalled.
module axis_out_reg256 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         beat_valid_i,
    input  logic [255:0] beat_data_i,
    input  logic [7:0]   beat_keep_i,
    input  logic         beat_last_i,
    output logic         adv_o,
    input  logic         m_tready_i,
    output logic         m_tvalid_o,
    output logic [255:0] m_tdata_o,
    output logic [7:0]   m_tkeep_o,
    output logic         m_tlast_o
);

    logic         tvalid_q;
    logic [255:0] tdata_q;
    logic [7:0]   tkeep_q;
    logic         tlast_q;

    assign adv_o = !tvalid_q || m_tready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
        end else if (adv_o) begin
            tvalid_q <= beat_valid_i;
            if (beat_valid_i) begin
                tdata_q <= beat_data_i;
                tkeep_q <= beat_keep_i;
                tlast_q <= beat_last_i;
            end
        end
    end

    assign m_tvalid_o = tvalid_q;
    assign m_tdata_o  = tdata_q;
    assign m_tkeep_o  = tkeep_q;
    assign m_tlast_o  = tlast_q;

endmodule

// File: rtl/cc_gearbox256.sv
// CC transmit gearbox: prepends the 3-DW descriptor to the payload stream,
// shifting payload up by 3 DW with carry between beats and a flush beat.
module cc_gearbox256
    import pcie_gearbox_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int DESC_WIDTH = 96
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cc_valid,
    output logic                  cc_ready,
    input  logic [DESC_WIDTH-1:0] cc_descriptor,
    input  logic [DATA_WIDTH-1:0] cc_payload,
    input  logic [7:0]            cc_payload_dw_keep,
    input  logic                  cc_payload_last,
    output logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
    output logic                  s_axis_cc_tvalid,
    input  logic                  s_axis_cc_tready,
    output logic [7:0]            s_axis_cc_tkeep,
    output logic                  s_axis_cc_tlast,
    output logic [32:0]           s_axis_cc_tuser
);

    localparam int CARRY_W = DESC_DW * DW_BITS;
    localparam int SPLIT_W = (BEAT_DW - DESC_DW) * DW_BITS;

    gb_state_e            state_q, state_d;
    logic [CARRY_W-1:0]   carry_q, carry_d;
    logic [1:0]           carry_dw_q, carry_dw_d;

    logic                  adv;
    logic                  accept;
    logic [3:0]            pay_dw;
    logic [3:0]            tail_dw;
    logic [3:0]            out_dw;
    logic                  beat_valid;
    logic                  beat_last;
    logic [7:0]            beat_keep;
    logic [DATA_WIDTH-1:0] beat_raw;
    logic [DATA_WIDTH-1:0] beat_data;

    assign pay_dw  = keep_popcount(cc_payload_dw_keep);
    // DWs of this beat that spill past the 5 DW slots left after the 3-DW head.
    assign tail_dw = (pay_dw > 4'd5) ? (pay_dw - 4'd5) : 4'd0;
    assign out_dw  = (pay_dw > 4'd5) ? 4'd8 : (pay_dw + 4'd3);

    assign cc_ready = adv && (state_q != GB_FLUSH);
    assign accept   = cc_valid && cc_ready;

    always_comb begin
        state_d    = state_q;
        carry_d    = carry_q;
        carry_dw_d = carry_dw_q;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_keep  = 8'h00;
        beat_raw   = '0;

        if (state_q == GB_FLUSH) begin
            beat_raw  = {{SPLIT_W{1'b0}}, carry_q};
            beat_keep = dw_count_to_keep({2'b00, carry_dw_q});
            beat_last = 1'b1;
            if (adv) begin
                beat_valid = 1'b1;
                state_d    = GB_IDLE;
            end
        end else if (accept) begin
            beat_valid = 1'b1;
            beat_raw   = {cc_payload[SPLIT_W-1:0],
                          (state_q == GB_IDLE) ? cc_descriptor : carry_q};
            beat_keep  = dw_count_to_keep(out_dw);
            carry_d    = cc_payload[DATA_WIDTH-1:SPLIT_W];
            carry_dw_d = tail_dw[1:0];
            if (!cc_payload_last) begin
                state_d = GB_BODY;
            end else if (tail_dw == 4'd0) begin
                beat_last = 1'b1;
                state_d   = GB_IDLE;
            end else begin
                state_d = GB_FLUSH;
            end
        end
    end

    // Zero every DW outside the keep so stale user or carry bits never leak out.
    generate
        for (genvar gi = 0; gi < BEAT_DW; gi++) begin : g_dw_mask
            assign beat_data[gi*DW_BITS +: DW_BITS] =
                beat_raw[gi*DW_BITS +: DW_BITS] & {DW_BITS{beat_keep[gi]}};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GB_IDLE;
            carry_q    <= '0;
            carry_dw_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            carry_q    <= carry_d;
            carry_dw_q <= carry_dw_d;
        end
    end

    axis_out_reg256 u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .beat_valid_i (beat_valid),
        .beat_data_i  (beat_data),
        .beat_keep_i  (beat_keep),
        .beat_last_i  (beat_last),
        .adv_o        (adv),
        .m_tready_i   (s_axis_cc_tready),
        .m_tvalid_o   (s_axis_cc_tvalid),
        .m_tdata_o    (s_axis_cc_tdata),
        .m_tkeep_o    (s_axis_cc_tkeep),
        .m_tlast_o    (s_axis_cc_tlast)
    );

    assign s_axis_cc_tuser = '0;

endmodule

// File: tb/tb_cc_gearbox256.sv
// Randomized bench for cc_gearbox256; expected beats come from chunking the
// descriptor+payload DW stream into 8-DW output beats.
module tb_cc_gearbox256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cc_valid;
    logic         cc_ready;
    logic [95:0]  cc_descriptor;
    logic [255:0] cc_payload;
    logic [7:0]   cc_payload_dw_keep;
    logic         cc_payload_last;
    logic [255:0] s_axis_cc_tdata;
    logic         s_axis_cc_tvalid;
    logic         s_axis_cc_tready;
    logic [7:0]   s_axis_cc_tkeep;
    logic         s_axis_cc_tlast;
    logic [32:0]  s_axis_cc_tuser;

    always #5 clk = ~clk;

    cc_gearbox256 #(.DATA_WIDTH(256), .DESC_WIDTH(96)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cc_valid           (cc_valid),
        .cc_ready           (cc_ready),
        .cc_descriptor      (cc_descriptor),
        .cc_payload         (cc_payload),
        .cc_payload_dw_keep (cc_payload_dw_keep),
        .cc_payload_last    (cc_payload_last),
        .s_axis_cc_tdata    (s_axis_cc_tdata),
        .s_axis_cc_tvalid   (s_axis_cc_tvalid),
        .s_axis_cc_tready   (s_axis_cc_tready),
        .s_axis_cc_tkeep    (s_axis_cc_tkeep),
        .s_axis_cc_tlast    (s_axis_cc_tlast),
        .s_axis_cc_tuser    (s_axis_cc_tuser)
    );

    typedef struct packed {
        logic [255:0] data;
        logic [7:0]   keep;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [95:0]  desc;
        logic [255:0] payload;
        logic [7:0]   keep;
        logic         last;
    } ubeat_t;

    ubeat_t in_q[$];
    beat_t  exp_q[$];
    beat_t  obs_q[$];

    int checks = 0;
    int errors = 0;
    int ready_low;
    int stall_viol;
    int cycles;
    bit timed_out;

    task automatic clear_queues();
        in_q.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    // Model: user beats carry the payload 8 DW at a time; output is the
    // descriptor DWs followed by payload DWs, cut into 8-DW beats.
    task automatic add_packet(input int ndw, input logic [95:0] desc, input bit aa_fill);
        logic [31:0] pay[$];
        logic [31:0] stream[$];
        logic [31:0] w;
        ubeat_t      ub;
        beat_t       eb;
        int          nbeats;
        int          nout;
        int          cnt;
        for (int i = 0; i < 3; i++) stream.push_back(desc[i*32 +: 32]);
        for (int i = 0; i < ndw; i++) begin
            w = aa_fill ? 32'hAAAA_AAAA : $urandom;
            pay.push_back(w);
            stream.push_back(w);
        end
        nbeats = (ndw == 0) ? 1 : (ndw + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            ub.desc = (b == 0) ? desc : {$urandom, $urandom, $urandom};
            cnt = 0;
            for (int d = 0; d < 8; d++) begin
                if (b*8 + d < ndw) begin
                    ub.payload[d*32 +: 32] = pay[b*8 + d];
                    cnt++;
                end else begin
                    ub.payload[d*32 +: 32] = $urandom;
                end
            end
            ub.keep = 8'((9'd1 << cnt) - 9'd1);
            ub.last = (b == nbeats - 1);
            in_q.push_back(ub);
        end
        nout = (stream.size() + 7) / 8;
        for (int o = 0; o < nout; o++) begin
            eb  = '0;
            cnt = 0;
            for (int d = 0; d < 8; d++) begin
                if (o*8 + d < stream.size()) begin
                    eb.data[d*32 +: 32] = stream[o*8 + d];
                    cnt++;
                end
            end
            eb.keep = 8'((9'd1 << cnt) - 9'd1);
            eb.last = (o == nout - 1);
            exp_q.push_back(eb);
        end
    endtask

    // mode 0: tready held high; 1: pattern 1,0,0 repeating; 2: random.
    task automatic run_traffic(input int mode, input int max_cycles);
        int           idx;
        bit           hold_active;
        logic [255:0] hold_data;
        logic [7:0]   hold_keep;
        logic         hold_last;
        idx = 0;
        hold_active = 1'b0;
        hold_data = '0;
        hold_keep = '0;
        hold_last = 1'b0;
        obs_q.delete();
        ready_low = 0;
        stall_viol = 0;
        cycles = 0;
        timed_out = 1'b0;
        while ((idx < in_q.size() || obs_q.size() < exp_q.size()) && !timed_out) begin
            @(negedge clk);
            case (mode)
                0:       s_axis_cc_tready = 1'b1;
                1:       s_axis_cc_tready = ((cycles % 3) == 0);
                default: s_axis_cc_tready = 1'($urandom_range(0, 1));
            endcase
            if (idx < in_q.size()) begin
                cc_valid           = 1'b1;
                cc_descriptor      = in_q[idx].desc;
                cc_payload         = in_q[idx].payload;
                cc_payload_dw_keep = in_q[idx].keep;
                cc_payload_last    = in_q[idx].last;
            end else begin
                cc_valid = 1'b0;
            end
            #1;
            if (hold_active && (!s_axis_cc_tvalid || s_axis_cc_tdata !== hold_data ||
                                s_axis_cc_tkeep !== hold_keep || s_axis_cc_tlast !== hold_last))
                stall_viol++;
            if (s_axis_cc_tvalid && !s_axis_cc_tready && cc_ready) stall_viol++;
            if (s_axis_cc_tvalid && s_axis_cc_tready) begin
                obs_q.push_back({s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast});
                $display("  out beat %0d: keep=%h last=%b data=%h", obs_q.size() - 1,
                         s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tdata);
            end
            hold_active = s_axis_cc_tvalid && !s_axis_cc_tready;
            hold_data   = s_axis_cc_tdata;
            hold_keep   = s_axis_cc_tkeep;
            hold_last   = s_axis_cc_tlast;
            if (!cc_ready) ready_low++;
            if (cc_valid && cc_ready) idx++;
            cycles++;
            if (cycles >= max_cycles) timed_out = 1'b1;
        end
        @(negedge clk);
        cc_valid = 1'b0;
        s_axis_cc_tready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cc_valid = 1'b0;
        cc_descriptor = '0;
        cc_payload = '0;
        cc_payload_dw_keep = '0;
        cc_payload_last = 1'b0;
        s_axis_cc_tready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_axis_cc_tvalid, s_axis_cc_tlast} !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid_last: got %b, expected 00", {s_axis_cc_tvalid, s_axis_cc_tlast});
        end
        checks++;
        if (s_axis_cc_tdata !== 256'd0 || s_axis_cc_tkeep !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_keep: got keep=%h data=%h, expected zeros", s_axis_cc_tkeep, s_axis_cc_tdata);
        end
        checks++;
        if (s_axis_cc_tuser !== 33'd0) begin
            errors++;
            $display("FAIL reset_tuser: got %h, expected 0", s_axis_cc_tuser);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (cc_ready !== 1'b1 || s_axis_cc_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready: got cc_ready=%b tvalid=%b, expected 1/0", cc_ready, s_axis_cc_tvalid);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_beat();
        logic [95:0] desc;
        clear_queues();
        desc = {$urandom, $urandom, $urandom};
        desc[28:16] = 13'd20;
        add_packet(5, desc, 1'b1);
        run_traffic(0, 200);
        checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_beat_count: got %0d beats (timeout=%0d), expected %0d", obs_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_beat[%0d]: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                         i, obs_q[i].keep, obs_q[i].last, obs_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].data);
            end
        end
        checks++;
        if (ready_low != 0) begin
            errors++;
            $display("FAIL single_beat_ready: got %0d cycles with cc_ready low, expected 0", ready_low);
        end
        $display("test_single_beat done");
    endtask

    task automatic test_two_beat();
        clear_queues();
        add_packet(13, {$urandom, $urandom, $urandom}, 1'b0);
        run_traffic(0, 200);
        checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL two_beat_count: got %0d beats (timeout=%0d), expected %0d", obs_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL two_beat[%0d]: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                         i, obs_q[i].keep, obs_q[i].last, obs_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].data);
            end
        end
        checks++;
        if (ready_low != 0) begin
            errors++;
            $display("FAIL two_beat_no_flush: got %0d cycles with cc_ready low, expected 0", ready_low);
        end
        $display("test_two_beat done");
    endtask

    task automatic test_flush();
        clear_queues();
        add_packet(16, {$urandom, $urandom, $urandom}, 1'b0);
        add_packet(5, {$urandom, $urandom, $urandom}, 1'b0);
        run_traffic(0, 200);
        checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL flush_count: got %0d beats (timeout=%0d), expected %0d", obs_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL flush[%0d]: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                         i, obs_q[i].keep, obs_q[i].last, obs_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].data);
            end
        end
        checks++;
        if (ready_low != 1) begin
            errors++;
            $display("FAIL flush_ready_bubble: got %0d cycles with cc_ready low, expected 1", ready_low);
        end
        $display("test_flush done");
    endtask

    task automatic test_desc_only();
        clear_queues();
        add_packet(0, {$urandom, $urandom, $urandom}, 1'b0);
        run_traffic(0, 200);
        checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL desc_only_count: got %0d beats (timeout=%0d), expected %0d", obs_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL desc_only[%0d]: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                         i, obs_q[i].keep, obs_q[i].last, obs_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].data);
            end
        end
        $display("test_desc_only done");
    endtask

    task automatic test_backpressure();
        clear_queues();
        add_packet(16, {$urandom, $urandom, $urandom}, 1'b0);
        run_traffic(1, 400);
        checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL backpressure_count: got %0d beats (timeout=%0d), expected %0d", obs_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL backpressure[%0d]: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                         i, obs_q[i].keep, obs_q[i].last, obs_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].data);
            end
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d stall violations, expected 0", stall_viol);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back();
        clear_queues();
        for (int p = 0; p < 6; p++) add_packet(int'($urandom_range(1, 24)), {$urandom, $urandom, $urandom}, 1'b0);
        run_traffic(0, 400);
        checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats (timeout=%0d), expected %0d", obs_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                         i, obs_q[i].keep, obs_q[i].last, obs_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].data);
            end
        end
        checks++;
        if (cycles != exp_q.size() + 1) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d cycles, expected %0d", cycles, exp_q.size() + 1);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        clear_queues();
        for (int p = 0; p < 15; p++) add_packet(int'($urandom_range(0, 40)), {$urandom, $urandom, $urandom}, 1'b0);
        run_traffic(2, 3000);
        checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d beats (timeout=%0d), expected %0d", obs_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random[%0d]: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                         i, obs_q[i].keep, obs_q[i].last, obs_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].data);
            end
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL random_hold: got %0d stall violations, expected 0", stall_viol);
        end
        $display("test_random done");
    endtask

    task automatic test_reset_mid();
        clear_queues();
        add_packet(20, {$urandom, $urandom, $urandom}, 1'b0);
        @(negedge clk);
        s_axis_cc_tready   = 1'b1;
        cc_valid           = 1'b1;
        cc_descriptor      = in_q[0].desc;
        cc_payload         = in_q[0].payload;
        cc_payload_dw_keep = in_q[0].keep;
        cc_payload_last    = in_q[0].last;
        #1;
        checks++;
        if (cc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_accept: got cc_ready=%b, expected 1", cc_ready);
        end
        @(negedge clk);
        cc_valid = 1'b0;
        #1;
        checks++;
        if (s_axis_cc_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_first_beat: got tvalid=%b, expected 1", s_axis_cc_tvalid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_axis_cc_tvalid !== 1'b0 || s_axis_cc_tkeep !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: got tvalid=%b tkeep=%h, expected 0/00", s_axis_cc_tvalid, s_axis_cc_tkeep);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_queues();
        add_packet(5, {$urandom, $urandom, $urandom}, 1'b0);
        run_traffic(0, 200);
        checks++;
        if (timed_out || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d beats (timeout=%0d), expected %0d", obs_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                         i, obs_q[i].keep, obs_q[i].last, obs_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].data);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beat();
        test_flush();
        test_desc_only();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
